// File: rtl/ttl_sched_pkg.sv
// Shared constants for the 7432 gate scheduler: gate count, per-gate state
// encoding and a lowest-set-bit helper used for gate selection.
package ttl_sched_pkg;

   localparam int NGATES = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Index of the lowest set bit; 0 when the vector is empty, so callers
   // qualify the result with an OR-reduction of the same vector.
   function automatic logic [1:0] lowest_set_idx(input logic [NGATES-1:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = NGATES - 1; i >= 0; i--) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: searches upward from ptr (mod NREQ) and
// moves ptr just past the winner only when a grant is actually taken.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NREQ-1:0] REQ,
   input  logic            ENABLE,
   input  logic            ADVANCE,
   output logic [NREQ-1:0] GNT,
   output logic [IDW-1:0]  GNT_IDX
);

   logic [IDW-1:0] ptr_q, ptr_d;
   logic           found;

   always_comb begin
      int idx;
      // NOTE: every comb output gets a default first so no path infers a latch.
      GNT     = '0;
      GNT_IDX = '0;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && REQ[idx]) begin
            found   = 1'b1;
            GNT_IDX = IDW'(idx);
         end
      end
      if (ENABLE && found) GNT[GNT_IDX] = 1'b1;

      ptr_d = ptr_q;
      if (ADVANCE) ptr_d = (GNT_IDX == IDW'(NREQ - 1)) ? '0 : GNT_IDX + IDW'(1);
   end

   // NOTE: clocked state uses <= so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/ttl_7432_gate_scheduler.sv
// Shares the four OR gates of one 7432 among NREQ requesters: grant, drive
// the gate, wait SETTLE clocks, sample Y and return a tagged response.
module ttl_7432_gate_scheduler
   import ttl_sched_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int SETTLE = 3,
   parameter int IDW    = $clog2(NREQ)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ,
   input  logic [NREQ-1:0]   REQ_A,
   input  logic [NREQ-1:0]   REQ_B,
   output logic [NREQ-1:0]   GNT,
   output logic [NGATES-1:0] GATE_A,
   output logic [NGATES-1:0] GATE_B,
   input  logic [NGATES-1:0] GATE_Y,
   output logic              RSP_VALID,
   output logic [IDW-1:0]    RSP_ID,
   output logic [1:0]        RSP_GATE,
   output logic              RSP_Y
);

   localparam int CNTW = $clog2(SETTLE + 1);

   logic [NGATES-1:0] idle_vec, done_vec, y_vec, pop;
   logic [IDW-1:0]    owner_arr [NGATES];
   logic [1:0]        gate_sel, rsp_sel;
   logic [IDW-1:0]    gnt_idx;
   logic              grant_any;

   assign gate_sel  = lowest_set_idx(idle_vec);
   assign grant_any = |GNT;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .CLK     (CLK),
      .RST     (RST),
      .REQ     (REQ),
      .ENABLE  ((|idle_vec) && !RST),
      .ADVANCE (grant_any),
      .GNT     (GNT),
      .GNT_IDX (gnt_idx)
   );

   for (genvar g = 0; g < NGATES; g++) begin : g_gate
      logic [1:0]      state_q, state_d;
      logic [CNTW-1:0] cnt_q, cnt_d;
      logic [IDW-1:0]  owner_q, owner_d;
      logic            y_q, y_d, a_q, a_d, b_q, b_d;
      logic            take;

      assign take = grant_any && (gate_sel == 2'(g));

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         owner_d = owner_q;
         y_d     = y_q;
         a_d     = a_q;
         b_d     = b_q;
         case (state_q)
            ST_IDLE: if (take) begin
               state_d = ST_BUSY;
               cnt_d   = CNTW'(SETTLE);
               owner_d = gnt_idx;
               a_d     = REQ_A[gnt_idx];
               b_d     = REQ_B[gnt_idx];
            end
            ST_BUSY: begin
               cnt_d = cnt_q - CNTW'(1);
               // Last settle clock: Y is passed through as-is, X included.
               if (cnt_q == CNTW'(1)) begin
                  y_d     = GATE_Y[g];
                  state_d = ST_DONE;
               end
            end
            ST_DONE: if (pop[g]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            y_q     <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            y_q     <= y_d;
            a_q     <= a_d;
            b_q     <= b_d;
         end
      end

      assign idle_vec[g]  = (state_q == ST_IDLE);
      assign done_vec[g]  = (state_q == ST_DONE);
      assign y_vec[g]     = y_q;
      assign owner_arr[g] = owner_q;
      assign GATE_A[g]    = a_q;
      assign GATE_B[g]    = b_q;
   end

   // One response per cycle; lower-index DONE gates win, the rest wait.
   assign rsp_sel = lowest_set_idx(done_vec);
   assign pop     = (|done_vec) ? (NGATES'(1) << rsp_sel) : '0;

   logic           rsp_valid_q, rsp_valid_d, rsp_y_q, rsp_y_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [1:0]     rsp_gate_q, rsp_gate_d;

   always_comb begin
      rsp_valid_d = |done_vec;
      rsp_id_d    = rsp_id_q;
      rsp_gate_d  = rsp_gate_q;
      rsp_y_d     = rsp_y_q;
      if (|done_vec) begin
         rsp_id_d   = owner_arr[rsp_sel];
         rsp_gate_d = rsp_sel;
         rsp_y_d    = y_vec[rsp_sel];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_gate_q  <= '0;
         rsp_y_q     <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_gate_q  <= rsp_gate_d;
         rsp_y_q     <= rsp_y_d;
      end
   end

   assign RSP_VALID = rsp_valid_q;
   assign RSP_ID    = rsp_id_q;
   assign RSP_GATE  = rsp_gate_q;
   assign RSP_Y     = rsp_y_q;

endmodule

// File: tb/tb_ttl_7432_gate_scheduler.sv
// Directed bench for the 7432 gate scheduler (NREQ=4, SETTLE=3) with an
// ideal OR-gate model closing the loop from GATE_A/GATE_B to GATE_Y.
module tb_ttl_7432_gate_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, req_a, req_b, gnt;
   logic [3:0] gate_a, gate_b, gate_y;
   logic       rsp_valid, rsp_y;
   logic [1:0] rsp_id, rsp_gate;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign gate_y = gate_a | gate_b;

   ttl_7432_gate_scheduler #(.NREQ(4), .SETTLE(3)) dut (
      .CLK       (clk),
      .RST       (rst),
      .REQ       (req),
      .REQ_A     (req_a),
      .REQ_B     (req_b),
      .GNT       (gnt),
      .GATE_A    (gate_a),
      .GATE_B    (gate_b),
      .GATE_Y    (gate_y),
      .RSP_VALID (rsp_valid),
      .RSP_ID    (rsp_id),
      .RSP_GATE  (rsp_gate),
      .RSP_Y     (rsp_y)
   );

   // Fairness run, one entry per cycle starting at the first grant cycle.
   localparam logic [3:0] FAIR_GNT  [10] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0000,
                                             4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0000};
   localparam logic       FAIR_V    [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
   localparam logic [1:0] FAIR_ID   [10] = '{0, 0, 0, 0, 0, 1, 2, 1, 2, 0};
   localparam logic [1:0] FAIR_GATE [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Leaves the bench at a negedge with RST low and two reset edges taken.
   task automatic do_reset();
      tick();
      rst = 1'b1;
      req = '0; req_a = '0; req_b = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_rsp(input string tag, input logic [1:0] id, input logic [1:0] g,
                            input logic y);
      check({tag, "_valid"}, rsp_valid, 1'b1);
      check({tag, "_id"}, rsp_id, id);
      check({tag, "_gate"}, rsp_gate, g);
      check({tag, "_y"}, rsp_y, y);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0] tt_a, tt_b;
      tt_a = 4'b1010;
      tt_b = 4'b1100;
      rst = 1'b0; req = '0; req_a = '0; req_b = '0;

      // Reset state, with requests asserted to show GNT is suppressed.
      tick();
      rst = 1'b1; req = 4'hF; req_a = 4'hF; req_b = 4'hF;
      #1 check("gnt_in_reset", gnt, 4'b0000);
      tick();
      tick();
      rst = 1'b0; req = '0; req_a = '0; req_b = '0;
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_id", rsp_id, 2'd0);
      check("rst_gate", rsp_gate, 2'd0);
      check("rst_y", rsp_y, 1'b0);
      check("rst_gate_a", gate_a, 4'b0000);
      check("rst_gate_b", gate_b, 4'b0000);

      // Truth table through gate 0: (A,B) = 00, 10, 01, 11 -> Y = 0,1,1,1.
      for (int i = 0; i < 4; i++) begin
         req = 4'b0001; req_a = {3'b0, tt_a[i]}; req_b = {3'b0, tt_b[i]};
         #1 check("tt_gnt", gnt, 4'b0001);
         tick();
         req = '0;
         check("tt_gate_a", gate_a[0], tt_a[i]);
         check("tt_gate_b", gate_b[0], tt_b[i]);
         repeat (3) begin
            check("tt_early", rsp_valid, 1'b0);
            tick();
         end
         check("tt_early", rsp_valid, 1'b0);
         tick();
         check_rsp("tt_rsp", 2'd0, 2'd0, tt_a[i] | tt_b[i]);
         tick();
         check("tt_pulse", rsp_valid, 1'b0);
         check("tt_hold_y", rsp_y, tt_a[i] | tt_b[i]);
      end

      // Saturation: four grants fill gates 0..3, then a stall, then r0 again.
      do_reset();
      req = 4'b1111; req_a = 4'b1111; req_b = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         #1 check("sat_gnt", gnt, 4'b0001 << k);
      end
      tick();
      check("sat_gate_a", gate_a, 4'b1111);
      #1 check("sat_stall", gnt, 4'b0000);
      tick();
      check_rsp("sat_rsp0", 2'd0, 2'd0, 1'b1);
      #1 check("sat_regrant", gnt, 4'b0001);
      tick();
      check_rsp("sat_rsp1", 2'd1, 2'd1, 1'b1);
      #1 check("sat_regrant1", gnt, 4'b0010);

      // Fairness: r1 and r2 held, alternating grants across gate reuse.
      do_reset();
      req = 4'b0110; req_a = 4'b0010; req_b = 4'b0000;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         check("fair_valid", rsp_valid, FAIR_V[k]);
         if (FAIR_V[k]) begin
            check("fair_id", rsp_id, FAIR_ID[k]);
            check("fair_gate", rsp_gate, FAIR_GATE[k]);
         end
         #1 check("fair_gnt", gnt, FAIR_GNT[k]);
      end

      // Gate fill order: r3 -> gate 0, then r0 -> gate 1; responses in order.
      do_reset();
      req = 4'b1000; req_a = 4'b1000; req_b = 4'b0000;
      #1 check("fill_gnt3", gnt, 4'b1000);
      tick();
      req = 4'b0001; req_a = 4'b0000;
      #1 check("fill_gnt0", gnt, 4'b0001);
      tick();
      req = '0;
      check("fill_gate_a", gate_a, 4'b0001);
      check("fill_gate_b", gate_b, 4'b0000);
      tick();
      tick();
      check("fill_early", rsp_valid, 1'b0);
      tick();
      check_rsp("fill_rsp_a", 2'd3, 2'd0, 1'b1);
      tick();
      check_rsp("fill_rsp_b", 2'd0, 2'd1, 1'b0);
      tick();
      check("fill_done", rsp_valid, 1'b0);

      // Reset mid-operation drops the in-flight op; ptr restarts at 0.
      do_reset();
      req = 4'b0100; req_a = 4'b0100; req_b = 4'b0100;
      #1 check("mid_gnt", gnt, 4'b0100);
      tick();
      req = '0;
      check("mid_gate_a", gate_a, 4'b0001);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_gate_a_clr", gate_a, 4'b0000);
      check("mid_gate_b_clr", gate_b, 4'b0000);
      for (int k = 0; k < 6; k++) begin
         check("mid_no_rsp", rsp_valid, 1'b0);
         tick();
      end
      req = 4'b1010; req_a = 4'b0010; req_b = 4'b0000;
      #1 check("mid_ptr0_gnt", gnt, 4'b0010);
      tick();
      req = '0;
      check("mid_gate0_a", gate_a, 4'b0001);
      repeat (4) tick();
      check_rsp("mid_rsp", 2'd1, 2'd0, 1'b1);

      // Withdrawal: r1 requests only while all gates are busy.
      do_reset();
      req = 4'b0001; req_a = 4'b0000; req_b = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         #1 check("wd_fill_gnt", gnt, 4'b0001);
      end
      tick();
      req = 4'b0010;
      #1 check("wd_busy_gnt", gnt, 4'b0000);
      tick();
      req = '0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         check("wd_valid", rsp_valid, k < 4);
         check("wd_id", rsp_id, 2'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
